// File: rtl/y_alu_pkg.sv
// Shared constants for the sequential ALU: op codes, FSM state encoding and default width.
// The MUL op code is only executed when YALU_MUL_EN is defined; otherwise it is reserved.
package y_alu_pkg;

  localparam int YALU_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_BUSY = 2'b01;
  localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/y_mul_seq.sv
// Shift-add multiplier returning the low WIDTH bits of the unsigned product, one step per cycle.
// done and product are combinational on the last step so the caller can register the result on that edge.
module y_mul_seq
  import y_alu_pkg::*;
#(
  parameter int WIDTH = YALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             run_reg;
  logic [WIDTH-1:0] addend;

  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign product = acc_reg + addend;
  // cnt_reg counts completed steps; the WIDTH-th step is the one in flight when it reads WIDTH-1
  assign done    = run_reg && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/y_alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides; single-cycle logic/arith ops and an
// optional WIDTH-cycle multiply enabled by the YALU_MUL_EN macro (absent: op 011 is reserved).
module y_alu_seq
  import y_alu_pkg::*;
#(
  parameter int WIDTH = YALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             cout,
  output logic             err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] z_reg, z_next;
  logic             zero_reg, zero_next;
  logic             cout_reg, cout_next;
  logic             err_reg, err_next;

  logic             accept;
  logic [WIDTH-1:0] alu_z;
  logic             alu_cout;
  logic             alu_err;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             slt;

  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);

  assign z    = z_reg;
  assign zero = zero_reg;
  assign cout = cout_reg;
  assign err  = err_reg;

`ifdef YALU_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && (op == OP_MUL);

  y_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  logic mul_start;
  assign mul_start = 1'b0;
`endif

  // Subtraction as a + ~b + 1 so the carry out doubles as the "no borrow" flag
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign slt     = $signed(a) < $signed(b);

  always_comb begin
    alu_z    = '0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    case (op)
      OP_AND: alu_z = a & b;
      OP_OR:  alu_z = a | b;
      OP_ADD: begin
        alu_z    = sum_add[WIDTH-1:0];
        alu_cout = sum_add[WIDTH];
      end
      OP_SUB: begin
        alu_z    = sum_sub[WIDTH-1:0];
        alu_cout = sum_sub[WIDTH];
      end
      OP_SLT: alu_z = {{(WIDTH-1){1'b0}}, slt};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    z_next     = z_reg;
    zero_next  = zero_reg;
    cout_next  = cout_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (mul_start) begin
            state_next = ST_BUSY;
          end else begin
            state_next = ST_DONE;
            z_next     = alu_z;
            zero_next  = (alu_z == '0);
            cout_next  = alu_cout;
            err_next   = alu_err;
          end
        end else if ((state_reg == ST_DONE) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
`ifdef YALU_MUL_EN
      ST_BUSY: begin
        if (mul_done) begin
          state_next = ST_DONE;
          z_next     = mul_product;
          zero_next  = (mul_product == '0);
          cout_next  = 1'b0;
          err_next   = 1'b0;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      z_reg     <= '0;
      zero_reg  <= 1'b1;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      z_reg     <= z_next;
      zero_reg  <= zero_next;
      cout_reg  <= cout_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_y_alu_seq.sv
// Self-checking bench for y_alu_seq: transaction-level reference model compared every cycle,
// directed literal checks for the corner cases, then randomized traffic. Honours YALU_MUL_EN.
module tb_y_alu_seq;
  import y_alu_pkg::*;

  localparam int W = 32;
`ifdef YALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         zero;
  logic         cout;
  logic         err;

  y_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero),
    .cout      (cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] z;
    logic         zero;
    logic         cout;
    logic         err;
  } res_t;

  // Reference model: whether a result is presented, cycles left on a multiply, and the results
  bit   m_valid;
  int   m_busy;
  res_t m_res;
  res_t m_pend;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_alu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    r.z = '0; r.cout = 1'b0; r.err = 1'b0;
    case (o)
      3'b000: r.z = x & y;
      3'b001: r.z = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        r.z = s[W-1:0];
        r.cout = s[W];
      end
      3'b110: begin
        r.z = x - y;
        r.cout = (x >= y);
      end
      3'b111: r.z = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      3'b011: begin
        if (MUL_EN) begin
          p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
          r.z = p[W-1:0];
        end else begin
          r.err = 1'b1;
        end
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.z == '0);
    return r;
  endfunction

  task automatic model_reset();
    m_valid     = 1'b0;
    m_busy      = 0;
    m_res.z     = '0;
    m_res.zero  = 1'b1;
    m_res.cout  = 1'b0;
    m_res.err   = 1'b0;
    m_pend      = m_res;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit rdy, acc;
    rdy = (m_busy == 0) && (!m_valid || out_ready);
    acc = in_valid && rdy;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1;
        m_res   = m_pend;
      end
    end else if (acc) begin
      if (MUL_EN && (op == 3'b011)) begin
        m_valid = 1'b0;
        m_busy  = W;
        m_pend  = ref_alu(op, a, b);
      end else begin
        m_valid = 1'b1;
        m_res   = ref_alu(op, a, b);
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then return 2 time units after it
  task automatic cycle(input logic v, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ordy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    out_ready = ordy;
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    chk("in_ready",  in_ready,  (m_busy == 0) && (!m_valid || out_ready));
    chk("out_valid", out_valid, m_valid);
    chk("z",         z,         m_res.z);
    chk("zero",      zero,      m_res.zero);
    chk("cout",      cout,      m_res.cout);
    chk("err",       err,       m_res.err);
  end

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int lowcnt;
  int vcnt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'b000; a = '0; b = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_z",         z,         '0);
    chk("rst_zero",      zero,      1'b1);
    chk("rst_in_ready",  in_ready,  1'b1);
    reset = 1'b0;

    cycle(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    $display("txn ADD ffffffff+1 -> z=%h zero=%b cout=%b err=%b", z, zero, cout, err);
    chk("add_valid", out_valid, 1'b1);
    chk("add_z",     z,         32'h0);
    chk("add_zero",  zero,      1'b1);
    chk("add_cout",  cout,      1'b1);
    chk("add_err",   err,       1'b0);

    cycle(1'b1, OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    $display("txn SLT 80000000,7fffffff -> z=%h", z);
    chk("slt_neg_z", z, 32'h1);
    chk("slt_neg_valid", out_valid, 1'b1);
    cycle(1'b1, OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    $display("txn SLT 7fffffff,80000000 -> z=%h zero=%b", z, zero);
    chk("slt_pos_z",    z,    32'h0);
    chk("slt_pos_zero", zero, 1'b1);
    cycle(1'b1, OP_SUB, 32'h5, 32'h7, 1'b1);
    $display("txn SUB 5-7 -> z=%h cout=%b", z, cout);
    chk("sub_z",    z,    32'hFFFF_FFFE);
    chk("sub_cout", cout, 1'b0);
    cycle(1'b1, 3'b100, 32'h1234, 32'h5678, 1'b1);
    $display("txn RSV 100 -> z=%h zero=%b err=%b", z, zero, err);
    chk("rsv_err",  err,  1'b1);
    chk("rsv_z",    z,    32'h0);
    chk("rsv_zero", zero, 1'b1);
`ifndef YALU_MUL_EN
    cycle(1'b1, OP_MUL, 32'h3, 32'h5, 1'b1);
    $display("txn MUL(disabled) -> z=%h err=%b", z, err);
    chk("mul_off_err",   err,       1'b1);
    chk("mul_off_z",     z,         32'h0);
    chk("mul_off_valid", out_valid, 1'b1);
`endif
    cycle(1'b0, OP_AND, '0, '0, 1'b1);
    chk("drain_valid", out_valid, 1'b0);

    cycle(1'b1, OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 1'b0);
    $display("txn OR hold -> z=%h", z);
    chk("or_z", z, 32'h0F0F_00F0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, OP_OR, $urandom, $urandom, 1'b0);
      chk("hold_z",        z,         32'h0F0F_00F0);
      chk("hold_in_ready", in_ready,  1'b0);
      chk("hold_valid",    out_valid, 1'b1);
    end
    cycle(1'b1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    $display("txn AND no-bubble -> z=%h valid=%b", z, out_valid);
    chk("and_valid", out_valid, 1'b1);
    chk("and_z",     z,         32'h0F00_0F00);
    cycle(1'b0, OP_AND, '0, '0, 1'b1);

`ifdef YALU_MUL_EN
    cycle(1'b1, OP_MUL, 32'h0001_0003, 32'h0000_0005, 1'b1);
    lowcnt = 0;
    vcnt   = 0;
    for (int i = 0; i < W; i++) begin
      if (in_ready === 1'b0) lowcnt++;
      if (out_valid === 1'b1) vcnt++;
      cycle(1'b0, OP_AND, $urandom, $urandom, 1'b1);
    end
    $display("txn MUL 00010003*5 -> z=%h busy=%0d", z, lowcnt);
    chk("mul_busy_cycles", lowcnt,    W);
    chk("mul_early_valid", vcnt,      0);
    chk("mul_valid",       out_valid, 1'b1);
    chk("mul_z",           z,         32'h0005_000F);
    cycle(1'b0, OP_AND, '0, '0, 1'b1);
`endif

    cycle(1'b1, OP_MUL, 32'h0001_0003, 32'h0000_0005, 1'b1);
    repeat (9) cycle(1'b0, OP_AND, '0, '0, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    $display("txn RESET mid-op -> valid=%b z=%h", out_valid, z);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_z",     z,         32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      cycle(1'b0, OP_AND, '0, '0, 1'b1);
      if (out_valid === 1'b1) vcnt++;
    end
    chk("abort_no_stale", vcnt, 0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
            ($urandom_range(0, 99) < 70));
      if (out_valid && out_ready)
        $display("txn rnd %0d -> z=%h zero=%b cout=%b err=%b", i, z, zero, cout, err);
    end
    repeat (W + 4) cycle(1'b0, OP_AND, '0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
